// File: rtl/ttrng_entropy_conditioner_if.sv
// Consumer-side bus of the TRNG entropy conditioner: enable, raw entropy, pop and FIFO/status outputs.
interface ttrng_entropy_conditioner_if #(
    parameter int CHANNELS   = 4,
    parameter int OUT_W      = 8,
    parameter int FIFO_DEPTH = 4
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic                ena;
    logic [CHANNELS-1:0] raw_bits;
    logic                rd;
    logic [OUT_W-1:0]    out_data;
    logic                out_valid;
    logic [LW-1:0]       level;
    logic                overflow;
    logic                health_fail;

    modport master (
        output ena, raw_bits, rd,
        input  out_data, out_valid, level, overflow, health_fail
    );

    modport slave (
        input  ena, raw_bits, rd,
        output out_data, out_valid, level, overflow, health_fail
    );
endinterface

// File: rtl/ttrng_entropy_conditioner.sv
// Entropy conditioner: 2-FF sync, XOR combine, repetition health test, optional von Neumann
// debias (TTRNG_VN_DEBIAS_EN), word assembler and show-ahead FIFO.
module ttrng_entropy_conditioner #(
    parameter int CHANNELS   = 4,
    parameter int OUT_W      = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int REP_LIMIT  = 16
) (
    input logic clk,
    input logic rst,
    ttrng_entropy_conditioner_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(OUT_W);

    logic [CHANNELS-1:0] s1_q, s2_q;
    logic                last_q, hf_q, ovf_q;
    logic [7:0]          rep_q, rep_d;
    logic [CW-1:0]       cnt_q;
    logic [OUT_W-1:0]    sh_q, word_d;
    logic [LW-1:0]       wp_q, rp_q, lvl;
    logic [OUT_W-1:0]    mem_q [FIFO_DEPTH];
    logic                c, adv, trip, emit_v, emit_b, push, pop, full, empty, wr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= bus.raw_bits;
            s2_q <= s1_q;
        end
    end

    assign c     = ^s2_q;
    assign adv   = bus.ena & ~hf_q;
    assign rep_d = (c == last_q) ? rep_q + 8'd1 : 8'd1;
    assign trip  = adv && (rep_d == 8'(REP_LIMIT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b0;
            rep_q  <= '0;
            hf_q   <= 1'b0;
        end else if (adv) begin
            last_q <= c;
            rep_q  <= rep_d;
            if (trip) hf_q <= 1'b1;
        end
    end

`ifdef TTRNG_VN_DEBIAS_EN
    typedef enum logic {DB_IDLE, DB_HAVE_FIRST} db_state_e;
    db_state_e db_q;
    logic      dba_q;

    assign emit_v = adv && (db_q == DB_HAVE_FIRST) && (c != dba_q);
    assign emit_b = dba_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_q  <= DB_IDLE;
            dba_q <= 1'b0;
        end else if (trip) begin
            db_q  <= DB_IDLE;
            dba_q <= 1'b0;
        end else if (adv) begin
            case (db_q)
                DB_IDLE: begin
                    dba_q <= c;
                    db_q  <= DB_HAVE_FIRST;
                end
                default: db_q <= DB_IDLE;
            endcase
        end
    end
`else
    assign emit_v = adv;
    assign emit_b = c;
`endif

    // First bit of a word ends up in the MSB.
    assign word_d = {sh_q[OUT_W-2:0], emit_b};
    assign push   = emit_v && (cnt_q == CW'(OUT_W - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            sh_q  <= '0;
        end else if (trip) begin
            cnt_q <= '0;
            sh_q  <= '0;
        end else if (emit_v) begin
            sh_q  <= word_d;
            cnt_q <= push ? '0 : cnt_q + CW'(1);
        end
    end

    assign lvl   = wp_q - rp_q;
    assign full  = (lvl == LW'(FIFO_DEPTH));
    assign empty = (lvl == '0);
    assign pop   = bus.rd & bus.out_valid;
    // A pop frees the slot the same edge, so a full FIFO still accepts a push alongside it.
    assign wr    = push & (~full | pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q  <= '0;
            rp_q  <= '0;
            ovf_q <= 1'b0;
        end else if (trip) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            if (wr)  wp_q <= wp_q + LW'(1);
            if (pop) rp_q <= rp_q + LW'(1);
            if (push && full && !pop) ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr && !trip) mem_q[wp_q[AW-1:0]] <= word_d;
    end

    assign bus.out_valid   = ~empty & ~hf_q;
    assign bus.out_data    = bus.out_valid ? mem_q[rp_q[AW-1:0]] : '0;
    assign bus.level       = lvl;
    assign bus.overflow    = ovf_q;
    assign bus.health_fail = hf_q;
endmodule

// File: tb/tb_ttrng_entropy_conditioner.sv
// Directed scoreboard bench for ttrng_entropy_conditioner (CHANNELS=4, OUT_W=8, FIFO_DEPTH=4).
module tb_ttrng_entropy_conditioner;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ttrng_entropy_conditioner_if #(.CHANNELS(4), .OUT_W(8), .FIFO_DEPTH(4)) bus ();

    ttrng_entropy_conditioner #(.CHANNELS(4), .OUT_W(8), .FIFO_DEPTH(4), .REP_LIMIT(16)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];
    logic en_d1 = 1'b0, en_d2 = 1'b0;
    bit seen_valid;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Pop monitor: a pop happens on the coming edge whenever rd and out_valid are both high.
    always begin
        @(negedge clk);
        #2;
        if (!rst && bus.rd && bus.out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected: got %0h expected none", bus.out_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                chk("pop_data", int'(bus.out_data), int'(e));
            end
        end
    end

    // Drives one combined bit; ena follows two cycles later so it lines up with the sync delay.
    task automatic step(input logic b, input logic en, input logic r);
        logic [2:0] rnd;
        @(negedge clk);
        rnd          = 3'($urandom_range(0, 7));
        bus.raw_bits = {rnd, b ^ (^rnd)};
        bus.ena      = en_d2;
        en_d2        = en_d1;
        en_d1        = en;
        bus.rd       = r;
        @(posedge clk);
        #1;
    endtask

    task automatic feed_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) step(w[i], 1'b1, 1'b0);
    endtask

    task automatic drain();
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst     = 1'b1;
        bus.ena = 1'b0;
        bus.rd  = 1'b0;
        en_d1   = 1'b0;
        en_d2   = 1'b0;
        exp_q.delete();
        #2;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        bus.ena      = 1'b0;
        bus.rd       = 1'b0;
        bus.raw_bits = '0;
        #1;
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_out_data", int'(bus.out_data), 0);
        chk("rst_level", int'(bus.level), 0);
        chk("rst_overflow", int'(bus.overflow), 0);
        chk("rst_health", int'(bus.health_fail), 0);
        reset_dut();

`ifdef TTRNG_VN_DEBIAS_EN
        begin
            logic [7:0] pat;
            pat = 8'b01100011;
            for (int r = 0; r < 4; r++)
                for (int i = 7; i >= 0; i--) step(pat[i], 1'b1, 1'b0);
            drain();
            chk("db_valid", int'(bus.out_valid), 1);
            chk("db_level", int'(bus.level), 1);
            exp_q.push_back(8'h55);
            step(1'b0, 1'b0, 1'b1);
            chk("db_empty", int'(bus.out_valid), 0);
        end
`else
        // First word 1010_1010 and its latency
        for (int i = 0; i < 8; i++) step(i % 2 == 0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("lat_valid_7bits", int'(bus.out_valid), 0);
        step(1'b0, 1'b0, 1'b0);
        chk("lat_valid_8bits", int'(bus.out_valid), 1);
        chk("lat_data", int'(bus.out_data), 'hAA);
        chk("lat_level", int'(bus.level), 1);
        feed_word(8'hC6);
        drain();
        chk("two_words_level", int'(bus.level), 2);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", int'(bus.out_valid), 0);
        chk("async_rst_data", int'(bus.out_data), 0);
        chk("async_rst_level", int'(bus.level), 0);
        reset_dut();

        // Overflow: five words, no reads; ena dropped mid-word in the first
        step(1'b0, 1'b1, 1'b0); step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0); step(1'b1, 1'b0, 1'b0); step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0); step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0); step(1'b1, 1'b1, 1'b0);
        feed_word(8'hC6);
        feed_word(8'h5A);
        feed_word(8'h96);
        feed_word(8'h69);
        drain();
        chk("ovf_level", int'(bus.level), 4);
        chk("ovf_flag", int'(bus.overflow), 1);
        chk("ovf_head", int'(bus.out_data), 'h35);
        exp_q.push_back(8'h35);
        exp_q.push_back(8'hC6);
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'h96);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1);
        chk("ovf_drained_valid", int'(bus.out_valid), 0);
        step(1'b0, 1'b0, 1'b1);
        chk("rd_empty_level", int'(bus.level), 0);
        reset_dut();

        // Full FIFO with pop and push on the same edge
        feed_word(8'h4B);
        feed_word(8'hB4);
        feed_word(8'h2D);
        feed_word(8'hD2);
        drain();
        chk("full_level", int'(bus.level), 4);
        exp_q.push_back(8'h4B);
        exp_q.push_back(8'hB4);
        exp_q.push_back(8'h2D);
        exp_q.push_back(8'hD2);
        exp_q.push_back(8'h39);
        feed_word(8'h39);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        chk("simul_level", int'(bus.level), 4);
        chk("simul_overflow", int'(bus.overflow), 0);
        chk("simul_head", int'(bus.out_data), 'hB4);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1);
        chk("simul_drained", int'(bus.level), 0);
        reset_dut();
`endif

        // Health: constant zero stream trips on the 16th enabled edge
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("hf_before", int'(bus.health_fail), 0);
`ifndef TTRNG_VN_DEBIAS_EN
        chk("hf_before_valid", int'(bus.out_valid), 1);
`endif
        step(1'b0, 1'b0, 1'b0);
        chk("hf_tripped", int'(bus.health_fail), 1);
        chk("hf_valid", int'(bus.out_valid), 0);
        chk("hf_level", int'(bus.level), 0);
        seen_valid = 1'b0;
        for (int i = 0; i < 24; i++) begin
            step(i[0], 1'b1, 1'b1);
            if (bus.out_valid) seen_valid = 1'b1;
        end
        chk("hf_blocks_output", int'(seen_valid), 0);
        chk("hf_sticky", int'(bus.health_fail), 1);
        reset_dut();
        #1;
        chk("hf_cleared", int'(bus.health_fail), 0);

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL leftover_words: got %0d expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ttrng_entropy_conditioner.md
# ttrng_entropy_conditioner

Parametrised entropy conditioner for the TinyTapeout TRNG. Takes CHANNELS raw, asynchronous entropy bits from the latch/oscillator network, synchronises and XOR-combines them, optionally von Neumann debiases, packs bits into OUT_W-bit words and buffers them in a show-ahead FIFO. A repetition-count health test latches a failure and blocks output. Sits between the raw entropy network and the `tt_um_ttrng` output pins.

## Interface
- CHANNELS, 4, number of raw entropy inputs (1..8)
- OUT_W, 8, output word width (2..8)
- FIFO_DEPTH, 4, FIFO entries (power of 2, ≥2)
- REP_LIMIT, 16, run length of identical combined bits that trips health failure (2..255)

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- ena  in  1  enable; 0 freezes consumption, state retained
- raw_bits  in  CHANNELS  asynchronous raw entropy
- rd  in  1  pop request
- out_data  out  OUT_W  FIFO head word (show-ahead)
- out_valid  out  1  FIFO non-empty and no health failure
- level  out  clog2(FIFO_DEPTH)+1  FIFO occupancy
- overflow  out  1  sticky: word dropped because FIFO full
- health_fail  out  1  sticky: repetition test tripped

## Operation
- Sync: raw_bits → s1 → s2 every clk regardless of ena. Combined bit c = XOR of s2.
- All stages below advance only on edges with ena=1 and health_fail=0.
- Health: last_bit, rep_cnt (8-bit). c==last_bit → rep_cnt+1, else rep_cnt=1; last_bit=c. When new rep_cnt == REP_LIMIT: health_fail=1 same edge, FIFO flushed (level=0), assembler and debias state cleared. Only rst clears health_fail.
- Debias (see Configuration): states IDLE / HAVE_FIRST. IDLE: store c as a, go HAVE_FIRST. HAVE_FIRST: if c≠a emit a; else emit nothing; go IDLE.
- Assembler: emitted bit shifted in at LSB, shift left (first bit ends in MSB); bit counter 0..OUT_W-1. On OUT_W-th bit, word pushed and counter wraps to 0.
- FIFO: push if not full, else word dropped and overflow=1 (sticky until rst). Pop when rd & out_valid; rd while empty ignored. Simultaneous pop and push when full: both succeed, level unchanged, no overflow. Same-edge push and pop when empty: push wins, level becomes 1.
- Word order preserved.

## Timing
- Reset values: s1, s2, last_bit, rep_cnt, bit counter, shift register, debias state (IDLE), FIFO pointers = 0; out_data=0, out_valid=0, level=0, overflow=0, health_fail=0.
- raw_bits captured at edge k is consumed at edge k+2.
- Word completed at edge n is visible on out_data with out_valid=1 after edge n (0 cycles extra).
- Pop at edge n: next word (or out_valid=0) after edge n.
- health_fail rises after the tripping edge; out_valid drops same edge.
- Reset mid-word: partial word discarded, asynchronously.
- ena low mid-pair or mid-word: state held; resumes exactly where it stopped.

## Configuration
- `TTRNG_VN_DEBIAS_EN` defined: debias stage as above; at most one bit emitted per two consumed bits.
- Not defined: debias stage absent; every consumed c is emitted directly to the assembler (one bit per enabled cycle). Health test behaves identically in both builds.

## Test plan
- Reset: assert rst mid-run with FIFO holding 2 words → all outputs 0 immediately, no clk needed.
- No-debias build, CHANNELS=4, OUT_W=8: raw_bits alternates 4'b0001/4'b0000 per cycle, ena raised after 3 cycles starting on a 1 → first word out_data=8'hAA, out_valid=1 exactly 8 enabled edges later.
- Debias build: combined stream repeating pairs 01,10,00,11 → emitted 0,1,… ; out_data=8'h55 after 32 consumed bits.
- Health: raw_bits held 0, REP_LIMIT=16 → health_fail=1 on 16th enabled edge, out_valid=0, level=0; later toggling inputs never raise out_valid until rst.
- Overflow: FIFO_DEPTH=4, rd=0, 5 words produced → level=4, overflow=1; then 4 pops return words 1..4 in order, out_valid=0 after.
- Full with simultaneous rd and push → level stays 4, overflow stays 0, head advances to next word.
